aes_round_control: RTL and testbench

AES_ROUND_CONTROL -- requirements
Module: aes_round_control

---
 rtl/aes_ctrl_pkg.sv | 36 +++
 rtl/aes_round_timer.sv | 49 ++++
 rtl/aes_round_control.sv | 134 +++++++++++++
 tb/tb_aes_round_control.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES round controller.
//   key_len_e  : 2-bit key length encoding carried on key_len
//   NR_*       : number of cipher rounds per key length
//   ctrl_state_e : controller FSM state (exposed for debug)
//   key_nr()   : key length to round count
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        KEY_128 = 2'd0,
        KEY_192 = 2'd1,
        KEY_256 = 2'd2,
        KEY_BAD = 2'd3
    } key_len_e;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } ctrl_state_e;

    // KEY_BAD never reaches here (requests with it are dropped);
    // it maps to NR_128 only to keep the function total.
    function automatic logic [3:0] key_nr(input key_len_e kl);
        logic [3:0] nr;
        case (kl)
            KEY_192: nr = NR_192;
            KEY_256: nr = NR_256;
            default: nr = NR_128;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_round_timer.sv
// Phase / round counters for the AES round controller.
//   clear      : force phase=0, round=0 (idle)
//   load       : start a block, phase=0, round=1
//   run        : advance phase, wrapping into the next round
//   round      : current round number (0 when cleared)
//   phase_zero : phase is 0 (first clock of a round)
//   phase_last : phase is CLK_PER_ROUND-1 (last clock of a round)
// Priority: clear > load > run.
module aes_round_timer #(
    parameter int CLK_PER_ROUND = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load,
    input  logic       run,
    output logic [3:0] round,
    output logic       phase_zero,
    output logic       phase_last
);

    localparam int PW = (CLK_PER_ROUND > 1) ? $clog2(CLK_PER_ROUND) : 1;

    logic [PW-1:0] phase;

    assign phase_zero = (phase == '0);
    assign phase_last = (phase == PW'(CLK_PER_ROUND - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            round <= 4'd0;
        end else if (clear) begin
            phase <= '0;
            round <= 4'd0;
        end else if (load) begin
            phase <= '0;
            round <= 4'd1;
        end else if (run) begin
            if (phase_last) begin
                phase <= '0;
                round <= round + 4'd1;
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

endmodule

// File: rtl/aes_round_control.sv
// AES round sequencer: accepts one-cycle block requests, steps through
// NR rounds of CLK_PER_ROUND clocks each and flags the result.
//   clk, rst_n     : clock, async active-low reset
//   kill           : synchronous abort to IDLE (clears pending slot)
//   in_en, key_len : block request and its key length
//   start          : pulse, first cycle of a block
//   round_idx      : current round 1..NR, 0 when idle
//   key_ready      : pulse, phase 0 of every round
//   en_mixcol      : high for the whole final round
//   out_en         : pulse, result valid
//   busy           : block in rounds
//   in_ready       : a new in_en will be accepted
//   collision_irq  : pulse, request dropped (no free slot)
//   mode_err       : pulse, request dropped (key_len=3)
//   state_dbg      : FSM state for debug
// Handshake: a request is taken when in_en=1 and in_ready=1 in the same
// cycle; in_en while in_ready=0 is dropped and reported via collision_irq.
module aes_round_control
    import aes_ctrl_pkg::*;
#(
    parameter int CLK_PER_ROUND = 4,
    parameter int PEND_EN       = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kill,
    input  logic        in_en,
    input  logic [1:0]  key_len,
    output logic        start,
    output logic [3:0]  round_idx,
    output logic        key_ready,
    output logic        en_mixcol,
    output logic        out_en,
    output logic        busy,
    output logic        in_ready,
    output logic        collision_irq,
    output logic        mode_err,
    output ctrl_state_e state_dbg
);

    ctrl_state_e state;
    logic [3:0]  nr_q;
    logic        slot_full;
    logic [1:0]  slot_key;
    logic        start_q, out_en_q, collision_q, mode_err_q;

    logic [3:0]  round;
    logic        phase_zero, phase_last;

    logic        key_bad, accept, block_done, launch;
    logic [1:0]  launch_key;
    logic        t_clear, t_load, t_run;

    always_comb begin
        in_ready   = 1'b1;
        if (state == ST_CALC)
            in_ready = (PEND_EN != 0) ? ~slot_full : 1'b0;
        key_bad    = (key_len == KEY_BAD);
        accept     = in_en & in_ready & ~key_bad;
        block_done = (state == ST_CALC) & phase_last & (round == nr_q);
        // A finishing block hands over to the pending slot first; with the
        // slot empty a request arriving in that same cycle launches directly.
        launch     = ((state == ST_IDLE) & accept) |
                     (block_done & (slot_full | accept));
        launch_key = (block_done & slot_full) ? slot_key : key_len;
        t_clear    = kill | (block_done & ~launch);
        t_load     = ~kill & launch;
        t_run      = (state == ST_CALC);
    end

    aes_round_timer #(
        .CLK_PER_ROUND (CLK_PER_ROUND)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (t_clear),
        .load       (t_load),
        .run        (t_run),
        .round      (round),
        .phase_zero (phase_zero),
        .phase_last (phase_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            nr_q        <= 4'd0;
            slot_full   <= 1'b0;
            slot_key    <= 2'd0;
            start_q     <= 1'b0;
            out_en_q    <= 1'b0;
            collision_q <= 1'b0;
            mode_err_q  <= 1'b0;
        end else if (kill) begin
            state       <= ST_IDLE;
            nr_q        <= 4'd0;
            slot_full   <= 1'b0;
            start_q     <= 1'b0;
            out_en_q    <= 1'b0;
            collision_q <= 1'b0;
            mode_err_q  <= 1'b0;
        end else begin
            start_q     <= launch;
            out_en_q    <= block_done;
            collision_q <= in_en & ~in_ready;
            mode_err_q  <= in_en & in_ready & key_bad;

            if (launch) begin
                state <= ST_CALC;
                nr_q  <= key_nr(key_len_e'(launch_key));
            end else if (block_done) begin
                state <= ST_IDLE;
            end

            if (block_done & slot_full) begin
                slot_full <= 1'b0;
            end else if ((state == ST_CALC) & ~block_done & accept) begin
                slot_full <= 1'b1;
                slot_key  <= key_len;
            end
        end
    end

    assign busy          = (state == ST_CALC);
    assign round_idx     = busy ? round : 4'd0;
    assign key_ready     = busy & phase_zero;
    assign en_mixcol     = busy & (round == nr_q);
    assign start         = start_q;
    assign out_en        = out_en_q;
    assign collision_irq = collision_q;
    assign mode_err      = mode_err_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_aes_round_control.sv
module tb_aes_round_control;
    import aes_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT a: CLK_PER_ROUND=4, pending slot enabled
    logic        a_kill = 1'b0, a_in_en = 1'b0;
    logic [1:0]  a_key_len = 2'd0;
    logic        a_start, a_key_ready, a_en_mixcol, a_out_en, a_busy;
    logic        a_in_ready, a_collision, a_mode_err;
    logic [3:0]  a_round_idx;
    ctrl_state_e a_state;

    // DUT b: CLK_PER_ROUND=1
    logic        b_kill = 1'b0, b_in_en = 1'b0;
    logic [1:0]  b_key_len = 2'd0;
    logic        b_start, b_key_ready, b_en_mixcol, b_out_en, b_busy;
    logic        b_in_ready, b_collision, b_mode_err;
    logic [3:0]  b_round_idx;
    ctrl_state_e b_state;

    int checks = 0;
    int failures = 0;

    aes_round_control #(.CLK_PER_ROUND(4), .PEND_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .kill(a_kill), .in_en(a_in_en), .key_len(a_key_len),
        .start(a_start), .round_idx(a_round_idx), .key_ready(a_key_ready),
        .en_mixcol(a_en_mixcol), .out_en(a_out_en), .busy(a_busy), .in_ready(a_in_ready),
        .collision_irq(a_collision), .mode_err(a_mode_err), .state_dbg(a_state)
    );

    aes_round_control #(.CLK_PER_ROUND(1), .PEND_EN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .kill(b_kill), .in_en(b_in_en), .key_len(b_key_len),
        .start(b_start), .round_idx(b_round_idx), .key_ready(b_key_ready),
        .en_mixcol(b_en_mixcol), .out_en(b_out_en), .busy(b_busy), .in_ready(b_in_ready),
        .collision_irq(b_collision), .mode_err(b_mode_err), .state_dbg(b_state)
    );

    // ---------------- driver ----------------
    // Advance one cycle; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [6:0] a_p, b_p;
        rst_n = 1'b0;
        repeat (3) step();
        a_p = {a_start, a_key_ready, a_en_mixcol, a_out_en, a_busy, a_collision, a_mode_err};
        b_p = {b_start, b_key_ready, b_en_mixcol, b_out_en, b_busy, b_collision, b_mode_err};
        checks++;
        if (a_p !== 7'd0) begin failures++; $display("FAIL reset_a_pulses got=%b exp=0000000", a_p); end
        checks++;
        if (b_p !== 7'd0) begin failures++; $display("FAIL reset_b_pulses got=%b exp=0000000", b_p); end
        checks++;
        if (a_round_idx !== 4'd0 || b_round_idx !== 4'd0) begin
            failures++; $display("FAIL reset_round_idx got=%0d/%0d exp=0/0", a_round_idx, b_round_idx);
        end
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b/%b exp=1/1", a_in_ready, b_in_ready);
        end
        checks++;
        if (a_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", a_state); end
        rst_n = 1'b1;
        step();
    endtask

    // AES-128, 4 clocks/round; key_len changed mid-block must not alter NR.
    task automatic test_aes128();
        logic [4:0] got, exp;
        logic [3:0] exp_round;
        int kr_count = 0;
        a_key_len = 2'd0; a_in_en = 1'b1;
        step();
        a_in_en = 1'b0; a_key_len = 2'd2;
        for (int k = 1; k <= 44; k++) begin
            exp = {k == 1, (k <= 40) && ((k - 1) % 4 == 0), (k >= 37) && (k <= 40), k == 41, k <= 40};
            exp_round = (k <= 40) ? 4'((k - 1) / 4 + 1) : 4'd0;
            got = {a_start, a_key_ready, a_en_mixcol, a_out_en, a_busy};
            if (a_key_ready === 1'b1) kr_count++;
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL aes128_flags k=%0d got=%b exp=%b (start,kr,mc,oe,busy)", k, got, exp);
            end
            checks++;
            if (a_round_idx !== exp_round) begin
                failures++; $display("FAIL aes128_round k=%0d got=%0d exp=%0d", k, a_round_idx, exp_round);
            end
            step();
        end
        a_key_len = 2'd0;
        checks++;
        if (kr_count != 10) begin failures++; $display("FAIL aes128_key_ready_count got=%0d exp=10", kr_count); end
    endtask

    // AES-256 with a single clock per round.
    task automatic test_aes256_cpr1();
        logic [4:0] got, exp;
        logic [3:0] exp_round;
        b_key_len = 2'd2; b_in_en = 1'b1;
        step();
        b_in_en = 1'b0; b_key_len = 2'd0;
        for (int k = 1; k <= 17; k++) begin
            exp = {k == 1, k <= 14, k == 14, k == 15, k <= 14};
            exp_round = (k <= 14) ? 4'(k) : 4'd0;
            got = {b_start, b_key_ready, b_en_mixcol, b_out_en, b_busy};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL aes256_flags k=%0d got=%b exp=%b (start,kr,mc,oe,busy)", k, got, exp);
            end
            checks++;
            if (b_round_idx !== exp_round) begin
                failures++; $display("FAIL aes256_round k=%0d got=%0d exp=%0d", k, b_round_idx, exp_round);
            end
            step();
        end
    endtask

    // Second request pends; third collides; exactly two results.
    task automatic test_back_to_back();
        int oe_count = 0, coll_count = 0;
        a_key_len = 2'd0; a_in_en = 1'b1;
        step();
        for (int k = 1; k <= 90; k++) begin
            a_in_en = (k == 5) || (k == 6);
            if (a_out_en === 1'b1) oe_count++;
            if (a_collision === 1'b1) coll_count++;
            if (k == 6) begin
                checks++;
                if (a_in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_full got=%b exp=0", a_in_ready); end
            end
            if (k == 7) begin
                checks++;
                if (a_collision !== 1'b1) begin failures++; $display("FAIL b2b_collision got=%b exp=1", a_collision); end
            end
            if (k == 41) begin
                checks++;
                if ({a_out_en, a_start, a_busy, a_key_ready} !== 4'b1111 || a_round_idx !== 4'd1) begin
                    failures++;
                    $display("FAIL b2b_handover got oe,start,busy,kr=%b round=%0d exp=1111 round=1",
                             {a_out_en, a_start, a_busy, a_key_ready}, a_round_idx);
                end
                checks++;
                if (a_in_ready !== 1'b1) begin failures++; $display("FAIL b2b_slot_freed got=%b exp=1", a_in_ready); end
            end
            if (k == 81) begin
                checks++;
                if (a_out_en !== 1'b1 || a_busy !== 1'b0) begin
                    failures++; $display("FAIL b2b_second_out got oe=%b busy=%b exp oe=1 busy=0", a_out_en, a_busy);
                end
            end
            step();
        end
        a_in_en = 1'b0;
        checks++;
        if (oe_count != 2) begin failures++; $display("FAIL b2b_out_en_count got=%0d exp=2", oe_count); end
        checks++;
        if (coll_count != 1) begin failures++; $display("FAIL b2b_collision_count got=%0d exp=1", coll_count); end
    endtask

    // key_len=3 while idle: mode_err only.
    task automatic test_illegal_mode();
        a_key_len = 2'd3; a_in_en = 1'b1;
        step();
        a_in_en = 1'b0; a_key_len = 2'd0;
        checks++;
        if ({a_mode_err, a_start, a_busy, a_collision} !== 4'b1000) begin
            failures++; $display("FAIL illegal_idle got me,start,busy,coll=%b exp=1000",
                                 {a_mode_err, a_start, a_busy, a_collision});
        end
        step();
        checks++;
        if ({a_mode_err, a_busy} !== 2'b00) begin
            failures++; $display("FAIL illegal_idle_after got me,busy=%b exp=00", {a_mode_err, a_busy});
        end
    endtask

    // Illegal request mid-block leaves slot empty; kill with pending slot aborts everything.
    task automatic test_kill();
        int oe_count = 0, start_count = 0;
        a_key_len = 2'd0; a_in_en = 1'b1;
        step();
        for (int k = 1; k <= 70; k++) begin
            a_in_en   = (k == 3) || (k == 5) || (k == 20);
            a_key_len = (k == 3) ? 2'd3 : 2'd1;
            a_kill    = (k == 20);
            if (a_out_en === 1'b1) oe_count++;
            if (k >= 21 && a_start === 1'b1) start_count++;
            if (k == 4) begin
                checks++;
                if ({a_mode_err, a_in_ready} !== 2'b11) begin
                    failures++; $display("FAIL kill_mid_mode_err got me,in_ready=%b exp=11", {a_mode_err, a_in_ready});
                end
            end
            if (k == 6) begin
                checks++;
                if (a_in_ready !== 1'b0) begin failures++; $display("FAIL kill_slot_taken got=%b exp=0", a_in_ready); end
            end
            if (k == 21) begin
                checks++;
                if (a_state !== ST_IDLE || a_busy !== 1'b0 || a_round_idx !== 4'd0) begin
                    failures++; $display("FAIL kill_idle got state=%0d busy=%b round=%0d exp 0/0/0",
                                         a_state, a_busy, a_round_idx);
                end
                checks++;
                if ({a_start, a_key_ready, a_en_mixcol, a_out_en, a_collision, a_mode_err} !== 6'd0) begin
                    failures++; $display("FAIL kill_pulses got=%b exp=000000",
                        {a_start, a_key_ready, a_en_mixcol, a_out_en, a_collision, a_mode_err});
                end
            end
            step();
        end
        a_kill = 1'b0;
        checks++;
        if (oe_count != 0 || start_count != 0) begin
            failures++; $display("FAIL kill_no_output got out_en=%0d start=%0d exp 0/0", oe_count, start_count);
        end
        // Fresh block: the slot must have been cleared by kill.
        a_key_len = 2'd0; a_in_en = 1'b1;
        step();
        a_in_en = 1'b0;
        checks++;
        if ({a_busy, a_in_ready} !== 2'b11) begin
            failures++; $display("FAIL kill_slot_cleared got busy,in_ready=%b exp=11", {a_busy, a_in_ready});
        end
        repeat (45) step();
    endtask

    // Reset in the middle of a block: no result is ever produced for it.
    task automatic test_reset_abort();
        int oe_count = 0;
        a_key_len = 2'd0; a_in_en = 1'b1;
        step();
        a_in_en = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({a_busy, a_in_ready, a_round_idx} !== {2'b01, 4'd0}) begin
            failures++; $display("FAIL reset_abort_state got busy=%b in_ready=%b round=%0d exp 0/1/0",
                                 a_busy, a_in_ready, a_round_idx);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (a_out_en === 1'b1) oe_count++;
            step();
        end
        checks++;
        if (oe_count != 0) begin failures++; $display("FAIL reset_abort_out_en got=%0d exp=0", oe_count); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_aes128();
        test_aes256_cpr1();
        test_back_to_back();
        test_illegal_mode();
        test_kill();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
